// File: rtl/cnn_stream_frontend.sv
// Stream front/back end for cnn_accelerator: assembles a byte-serial valid/ready
// stream into the weight and ifmap arrays, runs the accelerator, captures the
// pooled ofmap on done and replays it as a valid/ready output stream.
module cnn_stream_frontend #(
   parameter int DATA_WIDTH      = 8,
   parameter int IFMAP_SIZE      = 6,
   parameter int KERNEL_SIZE     = 3,
   parameter int POOL_OFMAP_SIZE = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [DATA_WIDTH-1:0]        s_data,
   input  logic                         reuse_w,
   output logic                         acc_en,
   output logic signed [DATA_WIDTH-1:0] acc_weights [KERNEL_SIZE][KERNEL_SIZE],
   output logic [DATA_WIDTH-1:0]        acc_ifmap [IFMAP_SIZE][IFMAP_SIZE],
   input  logic [DATA_WIDTH-1:0]        acc_ofmap [POOL_OFMAP_SIZE][POOL_OFMAP_SIZE],
   input  logic                         acc_done,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic                         m_last,
   output logic                         busy
);

   localparam int W_BEATS = KERNEL_SIZE * KERNEL_SIZE;
   localparam int X_BEATS = IFMAP_SIZE * IFMAP_SIZE;
   localparam int O_BEATS = POOL_OFMAP_SIZE * POOL_OFMAP_SIZE;
   localparam int IDX_W   = $clog2(X_BEATS);

   localparam logic [IDX_W-1:0] W_LAST = IDX_W'(W_BEATS - 1);
   localparam logic [IDX_W-1:0] X_LAST = IDX_W'(X_BEATS - 1);
   localparam logic [IDX_W-1:0] O_LAST = IDX_W'(O_BEATS - 1);

   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, RUN, UNLOAD} state_t;

   state_t                state;
   state_t                state_next;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] obuf [POOL_OFMAP_SIZE][POOL_OFMAP_SIZE];
   logic                  s_fire;
   logic                  m_fire;
   logic                  s_last;
   logic                  o_last;

   // One index serves every phase, so the terminal value depends on the state.
   assign s_last = (state == LOAD_W) ? (idx == W_LAST) : (idx == X_LAST);
   assign o_last = (idx == O_LAST);
   assign s_fire = s_valid && s_ready;
   assign m_fire = m_valid && m_ready;

   // State register; reset pulls acc_en and the stream handshakes low at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and control outputs, all decoded from the current state.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
      state_next = state;
      s_ready    = 1'b0;
      acc_en     = 1'b0;
      m_valid    = 1'b0;
      m_last     = 1'b0;
      m_data     = '0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy       = 1'b0;
            state_next = LOAD_W;
         end
         LOAD_W: begin
            s_ready = 1'b1;
            if (s_valid && s_last) state_next = LOAD_X;
         end
         LOAD_X: begin
            s_ready = 1'b1;
            if (s_valid && s_last) state_next = RUN;
         end
         RUN: begin
            acc_en = 1'b1;
            if (acc_done) state_next = UNLOAD;
         end
         UNLOAD: begin
            m_valid = 1'b1;
            m_last  = o_last;
            for (int r = 0; r < POOL_OFMAP_SIZE; r++)
               for (int c = 0; c < POOL_OFMAP_SIZE; c++)
                  if (idx == IDX_W'(r * POOL_OFMAP_SIZE + c)) m_data = obuf[r][c];
            if (m_ready && o_last) state_next = reuse_w ? LOAD_X : LOAD_W;
         end
         default: state_next = IDLE;
      endcase
   end

   // Shared index, input array assembly and output-buffer capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: these arrays drive the accelerator ports directly, so they are reset like any other state.
         idx <= '0;
         for (int r = 0; r < KERNEL_SIZE; r++)
            for (int c = 0; c < KERNEL_SIZE; c++)
               acc_weights[r][c] <= '0;
         for (int r = 0; r < IFMAP_SIZE; r++)
            for (int c = 0; c < IFMAP_SIZE; c++)
               acc_ifmap[r][c] <= '0;
         for (int r = 0; r < POOL_OFMAP_SIZE; r++)
            for (int c = 0; c < POOL_OFMAP_SIZE; c++)
               obuf[r][c] <= '0;
      end else begin
         if (s_fire) begin
            idx <= s_last ? '0 : idx + IDX_W'(1);
            if (state == LOAD_W) begin
               for (int r = 0; r < KERNEL_SIZE; r++)
                  for (int c = 0; c < KERNEL_SIZE; c++)
                     if (idx == IDX_W'(r * KERNEL_SIZE + c)) acc_weights[r][c] <= s_data;
            end else begin
               for (int r = 0; r < IFMAP_SIZE; r++)
                  for (int c = 0; c < IFMAP_SIZE; c++)
                     if (idx == IDX_W'(r * IFMAP_SIZE + c)) acc_ifmap[r][c] <= s_data;
            end
         end
         if (m_fire) idx <= o_last ? '0 : idx + IDX_W'(1);
         if (state == RUN && acc_done) begin
            for (int r = 0; r < POOL_OFMAP_SIZE; r++)
               for (int c = 0; c < POOL_OFMAP_SIZE; c++)
                  obuf[r][c] <= acc_ofmap[r][c];
         end
      end
   end

endmodule

// File: tb/tb_cnn_stream_frontend.sv
// Directed self-checking bench for cnn_stream_frontend with a small accelerator
// model that raises done 10 cycles after acc_en.
module tb_cnn_stream_frontend;

   localparam int DW = 8;
   localparam int N  = 6;
   localparam int K  = 3;
   localparam int P  = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 s_valid;
   logic                 s_ready;
   logic [DW-1:0]        s_data;
   logic                 reuse_w;
   logic                 acc_en;
   logic signed [DW-1:0] acc_weights [K][K];
   logic [DW-1:0]        acc_ifmap [N][N];
   logic [DW-1:0]        acc_ofmap [P][P];
   logic                 acc_done;
   logic                 m_valid;
   logic                 m_ready;
   logic [DW-1:0]        m_data;
   logic                 m_last;
   logic                 busy;

   int checks = 0;
   int errors = 0;

   // Hand-written weight table: 1, -1, 2..8 in row-major order.
   int exp_w [K*K] = '{1, -1, 2, 3, 4, 5, 6, 7, 8};
   logic [DW-1:0] exp_o [P*P];

   logic model_done    = 1'b0;
   logic spurious_done = 1'b0;
   int   model_cnt     = 0;
   logic bp [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   assign acc_done = model_done | spurious_done;

   cnn_stream_frontend #(
      .DATA_WIDTH(DW), .IFMAP_SIZE(N), .KERNEL_SIZE(K), .POOL_OFMAP_SIZE(P)
   ) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .reuse_w(reuse_w), .acc_en(acc_en),
      .acc_weights(acc_weights), .acc_ifmap(acc_ifmap), .acc_ofmap(acc_ofmap),
      .acc_done(acc_done),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Accelerator model: done pulses for one cycle, 10 cycles after acc_en rises.
   always @(posedge clk) begin
      #1;
      if (acc_en) begin
         model_cnt++;
         model_done = (model_cnt == 10);
      end else begin
         model_cnt  = 0;
         model_done = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic set_ofmap(input logic [DW-1:0] a, b, c, d);
      acc_ofmap[0][0] = a; acc_ofmap[0][1] = b;
      acc_ofmap[1][0] = c; acc_ofmap[1][1] = d;
      exp_o = '{a, b, c, d};
   endtask

   // Present one beat from a negedge and return at the negedge after it is taken.
   task automatic send_beat(input logic [DW-1:0] d, input bit gaps);
      int n;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = d;
      n = 0;
      while (s_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL s_ready_wait: s_ready=%b after %0d cycles, required 1", s_ready, n);
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send_frame(input int base, input bit gaps, input bit with_w);
      if (with_w)
         for (int i = 0; i < K*K; i++) send_beat(8'(exp_w[i]), gaps);
      for (int i = 0; i < N*N-1; i++) send_beat(8'(base + i), gaps);
      checks++;
      if (acc_en !== 1'b0) begin
         errors++;
         $display("FAIL acc_en_early: acc_en=%b before last pixel, required 0", acc_en);
      end
      send_beat(8'(base + N*N-1), gaps);
      checks++;
      if (acc_en !== 1'b1 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL acc_en_rise: acc_en=%b s_ready=%b, required 1/0", acc_en, s_ready);
      end
   endtask

   // Wait for done, then collect P*P beats; use_bp selects the m_ready pattern.
   task automatic drain_output(input bit use_bp);
      int n;
      int k;
      int cyc;
      n = 0;
      while (acc_done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (acc_done !== 1'b1 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL done_wait: acc_done=%b m_valid=%b, required 1/0", acc_done, m_valid);
      end
      @(negedge clk);
      k = 0;
      cyc = 0;
      while (k < P*P && cyc < 40) begin
         m_ready = use_bp ? bp[cyc % 8] : 1'b1;
         checks++;
         if (m_valid !== 1'b1 || m_data !== exp_o[k] || m_last !== (k == P*P-1)) begin
            errors++;
            $display("FAIL out_beat%0d: valid=%b data=%0d last=%b, required 1/%0d/%b",
                     k, m_valid, m_data, m_last, exp_o[k], (k == P*P-1));
         end
         if (m_ready) k++;
         @(negedge clk);
         cyc++;
      end
      m_ready = 1'b0;
      checks++;
      if (cyc != (use_bp ? 8 : P*P)) begin
         errors++;
         $display("FAIL out_cycles: took %0d cycles, required %0d", cyc, use_bp ? 8 : P*P);
      end
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL turnaround: m_valid=%b s_ready=%b, required 0/1", m_valid, s_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; s_valid = 1'b1; s_data = 8'h55; reuse_w = 1'b0; m_ready = 1'b0;
      set_ofmap(8'd10, 8'd20, 8'd30, 8'd40);
      repeat (3) @(negedge clk);
      checks++;
      if ({s_ready, acc_en, m_valid, m_last, busy} !== 5'b0 || m_data !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs: s_ready/acc_en/m_valid/m_last/busy=%b m_data=%0d, required 0",
                  {s_ready, acc_en, m_valid, m_last, busy}, m_data);
      end
      for (int i = 0; i < N*N; i++) begin
         checks++;
         if (acc_ifmap[i/N][i%N] !== 8'd0 || (i < K*K && acc_weights[i/K][i%K] !== 8'sd0)) begin
            errors++;
            $display("FAIL reset_array%0d: arrays not zero", i);
         end
      end
      reset = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_cycle: s_ready=%b busy=%b, required 0/0", s_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL load_w_entry: s_ready=%b busy=%b, required 1/1", s_ready, busy);
      end
      s_valid = 1'b0;
   endtask

   task automatic test_full_frame();
      send_frame(0, 1'b0, 1'b1);
      checks++;
      if (acc_weights[0][1] !== 8'hFF || acc_weights[2][2] !== 8'sd8 || acc_ifmap[5][5] !== 8'd35) begin
         errors++;
         $display("FAIL full_corners: w01=%h w22=%0d x55=%0d, required ff/8/35",
                  acc_weights[0][1], acc_weights[2][2], acc_ifmap[5][5]);
      end
      for (int i = 0; i < K*K; i++) begin
         checks++;
         if (int'(acc_weights[i/K][i%K]) !== exp_w[i]) begin
            errors++;
            $display("FAIL full_w%0d: got %0d, required %0d", i, acc_weights[i/K][i%K], exp_w[i]);
         end
      end
      for (int i = 0; i < N*N; i++) begin
         checks++;
         if (acc_ifmap[i/N][i%N] !== 8'(i)) begin
            errors++;
            $display("FAIL full_x%0d: got %0d, required %0d", i, acc_ifmap[i/N][i%N], i);
         end
      end
      drain_output(1'b0);
   endtask

   task automatic test_backpressure();
      send_frame(0, 1'b0, 1'b1);
      drain_output(1'b1);
   endtask

   task automatic test_input_gaps();
      send_frame(0, 1'b1, 1'b1);
      for (int i = 0; i < K*K; i++) begin
         checks++;
         if (int'(acc_weights[i/K][i%K]) !== exp_w[i]) begin
            errors++;
            $display("FAIL gaps_w%0d: got %0d, required %0d", i, acc_weights[i/K][i%K], exp_w[i]);
         end
      end
      for (int i = 0; i < N*N; i++) begin
         checks++;
         if (acc_ifmap[i/N][i%N] !== 8'(i)) begin
            errors++;
            $display("FAIL gaps_x%0d: got %0d, required %0d", i, acc_ifmap[i/N][i%N], i);
         end
      end
      reuse_w = 1'b1;
      drain_output(1'b0);
      reuse_w = 1'b0;
   endtask

   task automatic test_weight_reuse();
      send_frame(100, 1'b0, 1'b0);
      for (int i = 0; i < K*K; i++) begin
         checks++;
         if (int'(acc_weights[i/K][i%K]) !== exp_w[i]) begin
            errors++;
            $display("FAIL reuse_w%0d: got %0d, required %0d", i, acc_weights[i/K][i%K], exp_w[i]);
         end
      end
      for (int i = 0; i < N*N; i++) begin
         checks++;
         if (acc_ifmap[i/N][i%N] !== 8'(100 + i)) begin
            errors++;
            $display("FAIL reuse_x%0d: got %0d, required %0d", i, acc_ifmap[i/N][i%N], 100 + i);
         end
      end
      set_ofmap(8'd5, 8'd6, 8'd7, 8'd8);
      drain_output(1'b0);
      set_ofmap(8'd10, 8'd20, 8'd30, 8'd40);
      send_frame(0, 1'b0, 1'b1);
      drain_output(1'b0);
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < K*K; i++) send_beat(8'(exp_w[i]), 1'b0);
      for (int i = 0; i < 10; i++) send_beat(8'(50 + i), 1'b0);
      spurious_done = 1'b1;
      @(negedge clk);
      spurious_done = 1'b0;
      checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || acc_en !== 1'b0) begin
         errors++;
         $display("FAIL spurious_done: s_ready=%b m_valid=%b acc_en=%b, required 1/0/0",
                  s_ready, m_valid, acc_en);
      end
      for (int i = 10; i < 20; i++) send_beat(8'(50 + i), 1'b0);
      checks++;
      if (acc_ifmap[3][1] !== 8'd69) begin
         errors++;
         $display("FAIL partial_x19: got %0d, required 69", acc_ifmap[3][1]);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({s_ready, acc_en, m_valid, m_last, busy} !== 5'b0 || m_data !== 8'd0) begin
         errors++;
         $display("FAIL midreset_outputs: s_ready/acc_en/m_valid/m_last/busy=%b m_data=%0d, required 0",
                  {s_ready, acc_en, m_valid, m_last, busy}, m_data);
      end
      for (int i = 0; i < N*N; i++) begin
         checks++;
         if (acc_ifmap[i/N][i%N] !== 8'd0 || (i < K*K && acc_weights[i/K][i%K] !== 8'sd0)) begin
            errors++;
            $display("FAIL midreset_array%0d: arrays not zero", i);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      send_frame(0, 1'b0, 1'b1);
      for (int i = 0; i < N*N; i++) begin
         checks++;
         if (acc_ifmap[i/N][i%N] !== 8'(i) || (i < K*K && int'(acc_weights[i/K][i%K]) !== exp_w[i])) begin
            errors++;
            $display("FAIL reload_%0d: x=%0d, required %0d", i, acc_ifmap[i/N][i%N], i);
         end
      end
      drain_output(1'b0);
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_input_gaps();
      test_weight_reuse();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
